// File: rtl/srv_icb_sram.sv
// ICB responder terminating one crossbar port onto a single-port synchronous SRAM (1-cycle read latency).
// Optional address range checking: define SRV_ICB_SRAM_RANGE_CHK_EN.
module srv_icb_sram #(
  parameter int G_W_ADDR     = 32,
  parameter int G_W_DATA     = 32,
  parameter int G_DEPTH_LOG2 = 10,
  parameter int G_MPX        = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    active,
  output logic                    icb_cmd_ready,
  input  logic                    icb_cmd_valid,
  input  logic [G_W_ADDR-1:0]     icb_cmd_addr,
  input  logic                    icb_cmd_read,
  input  logic [G_W_DATA-1:0]     icb_cmd_wdata,
  input  logic [G_W_DATA/8-1:0]   icb_cmd_wmask,
  input  logic                    icb_resp_ready,
  output logic                    icb_resp_valid,
  output logic [G_W_DATA-1:0]     icb_resp_rdata,
  output logic                    icb_resp_err,
  output logic                    sram_cs,
  output logic                    sram_we,
  output logic [G_DEPTH_LOG2-1:0] sram_addr,
  output logic [G_W_DATA-1:0]     sram_wdata,
  output logic [G_W_DATA/8-1:0]   sram_wem,
  input  logic [G_W_DATA-1:0]     sram_rdata
);

  localparam int W_MASK = G_W_DATA / 8;
  localparam int OFS    = (W_MASK > 1) ? $clog2(W_MASK) : 0;
  localparam int W_CNT  = $clog2(G_MPX + 1);
  localparam int W_PTR  = (G_MPX > 1) ? $clog2(G_MPX) : 1;
  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(G_MPX);
  localparam logic [W_PTR-1:0] PTR_LAST = W_PTR'(G_MPX - 1);

  logic [W_CNT-1:0]    cnt_reg, cnt_next;
  logic [W_CNT-1:0]    fifo_cnt_reg, fifo_cnt_next;
  logic [W_PTR-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic                stage_vld_reg, stage_read_reg, stage_err_reg;
  logic [G_W_DATA-1:0] hold_rdata_reg;
  logic                hold_err_reg;
  logic [G_W_DATA-1:0] fifo_rdata [G_MPX];
  logic                fifo_err   [G_MPX];
  logic [G_W_DATA-1:0] push_rdata;
  logic                cmd_hs, resp_hs, fifo_push, in_range;
  logic                unused_addr;

`ifdef SRV_ICB_SRAM_RANGE_CHK_EN
  assign in_range = (icb_cmd_addr[G_W_ADDR-1:G_DEPTH_LOG2+OFS] == '0);
`else
  assign in_range = 1'b1;
`endif
  // Byte-offset bits (and upper bits when aliasing) never select a word.
  assign unused_addr = ^icb_cmd_addr;

  assign icb_cmd_ready = (cnt_reg != CNT_FULL);
  assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
  assign resp_hs       = icb_resp_valid && icb_resp_ready;
  assign active        = (cnt_reg != '0) | icb_cmd_valid;

  // SRAM port is a combinational pass-through, quiet whenever no command is offered.
  assign sram_cs    = cmd_hs && in_range && reset_n;
  assign sram_we    = icb_cmd_valid && !icb_cmd_read;
  assign sram_addr  = icb_cmd_valid ? icb_cmd_addr[G_DEPTH_LOG2+OFS-1:OFS] : '0;
  assign sram_wdata = icb_cmd_valid ? icb_cmd_wdata : '0;
  assign sram_wem   = icb_cmd_valid ? icb_cmd_wmask : '0;

  assign fifo_push  = stage_vld_reg;
  assign push_rdata = (stage_read_reg && !stage_err_reg) ? sram_rdata : '0;

  always_comb begin
    cnt_next      = cnt_reg;
    fifo_cnt_next = fifo_cnt_reg;
    if (cmd_hs && !resp_hs) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!cmd_hs && resp_hs) begin
      cnt_next = cnt_reg - 1'b1;
    end
    if (fifo_push && !resp_hs) begin
      fifo_cnt_next = fifo_cnt_reg + 1'b1;
    end else if (!fifo_push && resp_hs) begin
      fifo_cnt_next = fifo_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg        <= '0;
      fifo_cnt_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      stage_vld_reg  <= 1'b0;
      stage_read_reg <= 1'b0;
      stage_err_reg  <= 1'b0;
      hold_rdata_reg <= '0;
      hold_err_reg   <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      fifo_cnt_reg   <= fifo_cnt_next;
      stage_vld_reg  <= cmd_hs;
      if (cmd_hs) begin
        stage_read_reg <= icb_cmd_read;
        stage_err_reg  <= !in_range;
      end
      if (fifo_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (resp_hs) begin
        rd_ptr_reg     <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        // Keep the popped entry visible so the outputs hold while the FIFO is empty.
        hold_rdata_reg <= icb_resp_rdata;
        hold_err_reg   <= icb_resp_err;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < G_MPX; gi++) begin : g_fifo
      logic [G_W_DATA-1:0] rdata_reg;
      logic                err_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_reg <= '0;
          err_reg   <= 1'b0;
        end else if (fifo_push && (wr_ptr_reg == W_PTR'(gi))) begin
          rdata_reg <= push_rdata;
          err_reg   <= stage_err_reg;
        end
      end
      assign fifo_rdata[gi] = rdata_reg;
      assign fifo_err[gi]   = err_reg;
    end
  endgenerate

  assign icb_resp_valid = (fifo_cnt_reg != '0);
  assign icb_resp_rdata = icb_resp_valid ? fifo_rdata[rd_ptr_reg] : hold_rdata_reg;
  assign icb_resp_err   = icb_resp_valid ? fifo_err[rd_ptr_reg]   : hold_err_reg;

endmodule

// File: tb/tb_srv_icb_sram.sv
// Directed bench for srv_icb_sram: one instance with 2 credits, one with 4 for streaming.
module tb_srv_icb_sram;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A (G_MPX=2)
  logic        a_active, a_cmd_ready, a_valid, a_read, a_resp_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_addr, a_wdata, a_resp_rdata, a_sram_wdata, a_sram_rdata;
  logic [3:0]  a_wmask, a_sram_wem;
  logic        a_sram_cs, a_sram_we;
  logic [9:0]  a_sram_addr;
  // Instance B (G_MPX=4)
  logic        b_active, b_cmd_ready, b_valid, b_read, b_resp_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_addr, b_wdata, b_resp_rdata, b_sram_wdata, b_sram_rdata;
  logic [3:0]  b_wmask, b_sram_wem;
  logic        b_sram_cs, b_sram_we;
  logic [9:0]  b_sram_addr;

  srv_icb_sram #(.G_W_ADDR(32), .G_W_DATA(32), .G_DEPTH_LOG2(10), .G_MPX(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .active(a_active),
    .icb_cmd_ready(a_cmd_ready), .icb_cmd_valid(a_valid), .icb_cmd_addr(a_addr),
    .icb_cmd_read(a_read), .icb_cmd_wdata(a_wdata), .icb_cmd_wmask(a_wmask),
    .icb_resp_ready(a_resp_ready), .icb_resp_valid(a_resp_valid),
    .icb_resp_rdata(a_resp_rdata), .icb_resp_err(a_resp_err),
    .sram_cs(a_sram_cs), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
    .sram_wdata(a_sram_wdata), .sram_wem(a_sram_wem), .sram_rdata(a_sram_rdata)
  );

  srv_icb_sram #(.G_W_ADDR(32), .G_W_DATA(32), .G_DEPTH_LOG2(10), .G_MPX(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .active(b_active),
    .icb_cmd_ready(b_cmd_ready), .icb_cmd_valid(b_valid), .icb_cmd_addr(b_addr),
    .icb_cmd_read(b_read), .icb_cmd_wdata(b_wdata), .icb_cmd_wmask(b_wmask),
    .icb_resp_ready(b_resp_ready), .icb_resp_valid(b_resp_valid),
    .icb_resp_rdata(b_resp_rdata), .icb_resp_err(b_resp_err),
    .sram_cs(b_sram_cs), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
    .sram_wdata(b_sram_wdata), .sram_wem(b_sram_wem), .sram_rdata(b_sram_rdata)
  );

  // Behavioural SRAM macros, 1-cycle registered read.
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  always @(posedge clk) begin
    if (a_sram_cs) begin
      if (a_sram_we) begin
        for (int i = 0; i < 4; i++)
          if (a_sram_wem[i]) mem_a[a_sram_addr][8*i +: 8] <= a_sram_wdata[8*i +: 8];
      end else begin
        a_sram_rdata <= mem_a[a_sram_addr];
      end
    end
  end
  always @(posedge clk) begin
    if (b_sram_cs) begin
      if (b_sram_we) begin
        for (int j = 0; j < 4; j++)
          if (b_sram_wem[j]) mem_b[b_sram_addr][8*j +: 8] <= b_sram_wdata[8*j +: 8];
      end else begin
        b_sram_rdata <= mem_b[b_sram_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance A: handshake, stage cycle, response, drain.
  task automatic txn(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] wm, input logic exp_cs, input logic [9:0] exp_saddr,
                     input logic [31:0] exp_rdata, input logic exp_err);
    a_valid = 1'b1; a_read = rd; a_addr = addr; a_wdata = wd; a_wmask = wm;
    #1;
    chk("cmd_ready", a_cmd_ready, 1);
    chk("sram_cs", a_sram_cs, exp_cs);
    chk("sram_we", a_sram_we, !rd);
    chk("sram_addr", a_sram_addr, exp_saddr);
    chk("sram_wem", a_sram_wem, wm);
    @(negedge clk);
    a_valid = 1'b0; a_read = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '0;
    #1;
    chk("resp_early", a_resp_valid, 0);
    chk("sram_idle", a_sram_cs, 0);
    @(negedge clk); #1;
    chk("resp_valid", a_resp_valid, 1);
    chk("resp_rdata", a_resp_rdata, exp_rdata);
    chk("resp_err", a_resp_err, exp_err);
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    #1;
    chk("resp_drain", a_resp_valid, 0);
    chk("active_idle", a_active, 0);
    $display("txn %s addr=%h wdata=%h wmask=%h rdata=%h err=%0d",
             rd ? "RD" : "WR", addr, wd, wm, a_resp_rdata, a_resp_err);
  endtask

  initial begin
    reset_n = 1'b1;
    a_valid = 1'b0; a_read = 1'b0; a_addr = '0; a_wdata = '0; a_wmask = '0; a_resp_ready = 1'b0;
    b_valid = 1'b0; b_read = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0; b_resp_ready = 1'b1;
    a_sram_rdata = '0; b_sram_rdata = '0;
    #2 reset_n = 1'b0;
    a_valid = 1'b1; a_read = 1'b1; a_addr = 32'h10;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_sram_cs", a_sram_cs, 0);
    chk("rst_resp_valid", a_resp_valid, 0);
    chk("rst_resp_rdata", a_resp_rdata, 0);
    chk("rst_resp_err", a_resp_err, 0);
    chk("rst_cmd_ready", a_cmd_ready, 1);
    chk("rst_active_valid", a_active, 1);
    a_valid = 1'b0; a_read = 1'b0; a_addr = '0;
    #1;
    chk("rst_active", a_active, 0);
    chk("idle_sram_addr", a_sram_addr, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    // Full and partial writes, read-back.
    txn(1'b0, 32'h10, 32'hA5A5_5A5A, 4'hF, 1'b1, 10'h004, 32'h0, 1'b0);
    txn(1'b1, 32'h10, 32'h0,         4'h0, 1'b1, 10'h004, 32'hA5A5_5A5A, 1'b0);
    txn(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b1, 10'h008, 32'h0, 1'b0);
    txn(1'b0, 32'h20, 32'h1234_5678, 4'h3, 1'b1, 10'h008, 32'h0, 1'b0);
    txn(1'b1, 32'h22, 32'h0,         4'h0, 1'b1, 10'h008, 32'hFFFF_5678, 1'b0);
    txn(1'b0, 32'h20, 32'h0,         4'h0, 1'b1, 10'h008, 32'h0, 1'b0);
    txn(1'b1, 32'h20, 32'h0,         4'h0, 1'b1, 10'h008, 32'hFFFF_5678, 1'b0);
    txn(1'b0, 32'h0,  32'hCAFE_F00D, 4'hF, 1'b1, 10'h000, 32'h0, 1'b0);
`ifdef SRV_ICB_SRAM_RANGE_CHK_EN
    txn(1'b1, 32'h1000, 32'h0, 4'h0, 1'b0, 10'h000, 32'h0, 1'b1);
`else
    txn(1'b1, 32'h1000, 32'h0, 4'h0, 1'b1, 10'h000, 32'hCAFE_F00D, 1'b0);
`endif

    // Back-pressure: two credits, third command stalls until a response drains.
    a_valid = 1'b1; a_read = 1'b1; a_addr = 32'h10;
    #1 chk("bp_ready0", a_cmd_ready, 1);
    @(negedge clk); a_addr = 32'h20;
    #1 chk("bp_ready1", a_cmd_ready, 1);
    @(negedge clk); a_addr = 32'h0;
    #1;
    chk("bp_stall_ready", a_cmd_ready, 0);
    chk("bp_stall_cs", a_sram_cs, 0);
    chk("bp_active", a_active, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_ready", a_cmd_ready, 0);
      chk("bp_head_valid", a_resp_valid, 1);
      chk("bp_head_rdata", a_resp_rdata, 32'hA5A5_5A5A);
    end
    a_resp_ready = 1'b1;
    #1 chk("bp_pop0_ready", a_cmd_ready, 0);
    @(negedge clk); #1;
    chk("bp_r1_valid", a_resp_valid, 1);
    chk("bp_r1_rdata", a_resp_rdata, 32'hFFFF_5678);
    chk("bp_third_ready", a_cmd_ready, 1);
    chk("bp_third_cs", a_sram_cs, 1);
    chk("bp_third_addr", a_sram_addr, 0);
    @(negedge clk); a_valid = 1'b0; a_read = 1'b0; a_addr = '0;
    #1;
    chk("bp_gap_valid", a_resp_valid, 0);
    chk("bp_gap_hold", a_resp_rdata, 32'hFFFF_5678);
    @(negedge clk); #1;
    chk("bp_r2_valid", a_resp_valid, 1);
    chk("bp_r2_rdata", a_resp_rdata, 32'hCAFE_F00D);
    @(negedge clk); a_resp_ready = 1'b0;
    #1;
    chk("bp_done_valid", a_resp_valid, 0);
    chk("bp_done_active", a_active, 0);
    $display("txn BP three reads drained in order");

    // Reset with two responses pending.
    a_valid = 1'b1; a_read = 1'b1; a_addr = 32'h10;
    @(negedge clk); a_addr = 32'h20;
    @(negedge clk); a_valid = 1'b0; a_read = 1'b0; a_addr = '0;
    @(negedge clk); #1;
    chk("pre_rst_valid", a_resp_valid, 1);
    chk("pre_rst_ready", a_cmd_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_resp_valid, 0);
    chk("mid_rst_ready", a_cmd_ready, 1);
    chk("mid_rst_active", a_active, 0);
    chk("mid_rst_rdata", a_resp_rdata, 0);
    @(negedge clk); @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("post_rst_no_stale", a_resp_valid, 0);
      chk("post_rst_ready", a_cmd_ready, 1);
    end
    $display("txn RESET with two pending responses");
    txn(1'b1, 32'h10, 32'h0, 4'h0, 1'b1, 10'h004, 32'hA5A5_5A5A, 1'b0);

    // Streaming on the 4-credit instance: 8 writes then 8 reads, one per cycle.
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        b_valid = 1'b1; b_read = (c >= 8); b_addr = 32'(4 * (c % 8));
        b_wdata = 32'h1000_0000 + 32'(c); b_wmask = 4'hF;
      end else begin
        b_valid = 1'b0; b_read = 1'b0; b_addr = '0; b_wdata = '0; b_wmask = '0;
      end
      #1;
      if (c < 16) chk("b_cmd_ready", b_cmd_ready, 1);
      chk("b_resp_valid", b_resp_valid, (c >= 2 && c < 18) ? 32'd1 : 32'd0);
      if (c >= 2 && c < 18) begin
        chk("b_resp_rdata", b_resp_rdata, (c >= 10) ? 32'h1000_0000 + 32'(c - 10) : 32'h0);
        chk("b_resp_err", b_resp_err, 0);
        $display("txn B resp cycle=%0d rdata=%h", c, b_resp_rdata);
      end
      @(negedge clk);
    end
    #1 chk("b_active_end", b_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
